// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, shift schedule,
// plus the PC-1 and 28-bit rotate helpers used by the schedule datapaths.
package des_pkg;

  localparam int CD_W = 28;
  localparam int SK_W = 48;

  typedef enum logic {IDLE, RUN} state_t;

  // Tables hold 1-based DES bit positions, MSB of each vector is position 1.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Indexed by round number minus 1.
  localparam int unsigned SHIFT_TAB [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [2*CD_W-1:0] pc1(input logic [63:0] key);
    logic [2*CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < 2*CD_W; i++) cd[2*CD_W-1-i] = key[64-PC1_TAB[i]];
    return cd;
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input int unsigned s);
    return (x >> s) | (x << (CD_W - s));
  endfunction

endpackage

// File: rtl/des_key_sched_dec_if.sv
// Key request and subkey stream bundle between the decrypt core and the schedule.
interface des_key_sched_dec_if
  import des_pkg::*;
;
  logic [63:0]     key_in;
  logic            start;
  logic [SK_W-1:0] subkey;
  logic            subkey_valid;
  logic            subkey_ready;
  logic [3:0]      round;
  logic            last;
  logic            busy;

  modport master (
    output key_in, start, subkey_ready,
    input  subkey, subkey_valid, round, last, busy
  );

  modport slave (
    input  key_in, start, subkey_ready,
    output subkey, subkey_valid, round, last, busy
  );
endinterface

// File: rtl/des_pc2.sv
// PC-2 compression permutation, 56-bit C||D to 48-bit subkey. Shared with the
// encrypt-direction schedule.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [SK_W-1:0]   subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SK_W; i++) subkey[SK_W-1-i] = cd[2*CD_W-PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_sched_dec.sv
// Decrypt-direction DES key schedule: emits K16 down to K1, one per handshake,
// by right-rotating C/D from the unrotated PC-1 state.
module des_key_sched_dec
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_sched_dec_if.slave   bus
);

  state_t          state_q, state_d;
  logic [CD_W-1:0] c_q, c_d;
  logic [CD_W-1:0] d_q, d_d;
  logic [3:0]      round_q, round_d;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          {c_d, d_d} = pc1(bus.key_in);
          round_d    = 4'd15;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            // Undo the left shift that produced round_q+1 to reach round_q.
            c_d     = rotr(c_q, SHIFT_TAB[round_q]);
            d_d     = rotr(d_q, SHIFT_TAB[round_q]);
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (bus.subkey)
  );

  assign bus.subkey_valid = (state_q == RUN);
  assign bus.busy         = (state_q == RUN);
  assign bus.round        = round_q;
  assign bus.last         = (state_q == RUN) && (round_q == 4'd0);

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Scoreboard bench for des_key_sched_dec against a cumulative-rotation DES key model.
module tb_des_key_sched_dec;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_key_sched_dec_if bus();

  des_key_sched_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int PC1_M [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_M [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_M [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        lst;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   check_known = 0;

  // Encrypt-order K_n: C0/D0 rotated left by the cumulative shift count.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    bit c[28];
    bit d[28];
    bit cd[56];
    int tot;
    logic [47:0] k;
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH_M[i];
    for (int j = 0; j < 28; j++) begin
      c[j] = key[64-PC1_M[j]];
      d[j] = key[64-PC1_M[28+j]];
    end
    for (int j = 0; j < 28; j++) begin
      cd[j]    = c[(j+tot)%28];
      cd[28+j] = d[(j+tot)%28];
    end
    for (int i = 0; i < 48; i++) k[47-i] = cd[PC2_M[i]-1];
    return k;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic push_sched(input logic [63:0] key);
    exp_t e;
    for (int n = 16; n >= 1; n--) begin
      e.sk  = ref_subkey(key, n);
      e.rnd = 4'(n-1);
      e.lst = (n == 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake, checks hold during backpressure.
  logic        have_hold = 0;
  logic [47:0] hold_sk;
  logic [3:0]  hold_rnd;
  logic        hold_lst;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_hold = 0;
    end else begin
      if (have_hold) begin
        chk("hold_valid", bus.subkey_valid, 1);
        chk("hold_subkey", bus.subkey, hold_sk);
        chk("hold_round", bus.round, hold_rnd);
        chk("hold_last", bus.last, hold_lst);
      end
      if (bus.subkey_valid && bus.subkey_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_subkey actual=%h required=none", bus.subkey);
        end else begin
          e = sb_q.pop_front();
          chk("sb_subkey", bus.subkey, e.sk);
          chk("sb_round", bus.round, e.rnd);
          chk("sb_last", bus.last, e.lst);
        end
      end
      have_hold = bus.subkey_valid && !bus.subkey_ready;
      hold_sk   = bus.subkey;
      hold_rnd  = bus.round;
      hold_lst  = bus.last;
    end
  end

  task automatic run_key(input logic [63:0] key, input logic [63:0] exp_key,
                         input bit bp, input bit mid_start);
    int cyc;
    push_sched(exp_key);
    bus.key_in = key;
    bus.start  = 1;
    bus.subkey_ready = 1;
    tick();
    bus.start  = 0;
    bus.key_in = {$urandom, $urandom};
    chk("latency_valid", bus.subkey_valid, 1);
    chk("first_round", bus.round, 15);
    if (check_known) chk("kat_k16", bus.subkey, 48'hCB3D8B0E17F5);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      if (check_known && bus.round == 0) begin
        chk("kat_k1", bus.subkey, 48'h1B02EFFC7072);
        chk("kat_last", bus.last, 1);
      end
      if (mid_start && bus.round == 8) begin
        bus.start  = 1;
        bus.key_in = ~exp_key;
      end else begin
        bus.start  = 0;
      end
      bus.subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    bus.start = 0;
    chk("sched_bounded", cyc < 200, 1);
    chk("idle_valid", bus.subkey_valid, 0);
    chk("queue_drained", sb_q.size(), 0);
  endtask

  initial begin
    logic [63:0] ka, kb, kd;
    int cyc;
    rst_n = 0;
    bus.start = 0;
    bus.subkey_ready = 0;
    bus.key_in = '0;
    #3;
    chk("rst_valid", bus.subkey_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_subkey", bus.subkey, 0);
    tick();
    rst_n = 1;
    tick();

    check_known = 1;
    run_key(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 0, 0);
    check_known = 0;
    run_key(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1, 0);
    run_key(64'h0, 64'h0, 0, 0);
    run_key({64{1'b1}}, {64{1'b1}}, 1, 0);

    ka = {$urandom, $urandom};
    run_key(ka, ka, 1, 1);

    // Start coinciding with the K1 handshake is dropped; one cycle later it is taken.
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    push_sched(ka);
    bus.key_in = ka;
    bus.start = 1;
    bus.subkey_ready = 1;
    tick();
    bus.start = 0;
    cyc = 0;
    while (!(bus.subkey_valid && bus.round == 0) && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("k1_reached", cyc < 40, 1);
    bus.start = 1;
    bus.key_in = kb;
    tick();
    chk("k1_start_ignored", bus.busy, 0);
    push_sched(kb);
    tick();
    bus.start = 0;
    chk("restart_valid", bus.subkey_valid, 1);
    chk("restart_round", bus.round, 15);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("restart_done", cyc < 40, 1);
    chk("restart_drained", sb_q.size(), 0);

    // Asynchronous reset between edges at round 5.
    ka = {$urandom, $urandom};
    push_sched(ka);
    bus.key_in = ka;
    bus.start = 1;
    tick();
    bus.start = 0;
    cyc = 0;
    while (bus.round != 5 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("reach_round5", bus.round, 5);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.subkey_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_last", bus.last, 0);
    chk("mid_rst_subkey", bus.subkey, 0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1;
    tick();
    kb = {$urandom, $urandom};
    run_key(kb, kb, 0, 0);

    for (int i = 0; i < 100; i++) begin
      ka = {$urandom, $urandom};
      kd = (i % 4 == 0) ? (ka ^ (64'h1 << (8 * $urandom_range(0, 7)))) : ka;
      run_key(kd, ka, (i % 2) == 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
